// File: rtl/if_id_stage_buf_pkg.sv
// Shared IF/ID definitions: the fetch/decode entry layout and the bubble opcode
// that decode sees whenever the buffer is empty.
package structures;

   localparam int INSTR_W_DEF = 32;
   localparam int PC_W_DEF    = 64;

   // A64 NOP, injected as the head instruction while the buffer is empty
   localparam logic [31:0] BUBBLE_INSTR = 32'hD503201F;

   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [PC_W_DEF-1:0]    pc;
   } if_id_entry_t;

endpackage

// File: rtl/if_id_stage_buf_mem.sv
// Entry storage for the IF/ID elastic buffer: synchronous write, asynchronous read.
// Deliberately unreset; validity is tracked entirely by the occupancy counter.
module stage_buf_mem #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 96,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_stage_buf.sv
// IF/ID elastic buffer: DEPTH-entry circular queue between fetch and decode with
// valid/ready on both sides, flush, and bubble substitution when empty.
module if_id_stage_buf
   import structures::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 64,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction_in,
   input  logic [PC_W-1:0]    pc_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instruction_out,
   output logic [PC_W-1:0]    pc_out,
   output logic [CNT_W-1:0]   count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int DATA_W = INSTR_W + PC_W;

   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] rd_data;

   // Handshake outputs depend only on registered occupancy, so a full buffer
   // cannot pass an input straight through in the cycle it is popped.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   stage_buf_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push && !flush),
      .wr_addr (wr_ptr),
      .wr_data ({instruction_in, pc_in}),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   assign instruction_out = out_valid ? rd_data[DATA_W-1 -: INSTR_W] : INSTR_W'(BUBBLE_INSTR);
   assign pc_out          = out_valid ? rd_data[PC_W-1:0] : '0;

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Bench for if_id_stage_buf: a DEPTH=2 and a DEPTH=4 instance, each shadowed by a
// queue-based reference of the buffer's contents.
module tb_if_id_stage_buf;
   import structures::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        rst2, flush2, in_valid2, in_ready2, out_valid2, out_ready2;
   logic [31:0] instr_in2, instr_out2;
   logic [63:0] pc_in2, pc_out2;
   logic [1:0]  count2;

   logic        rst4, flush4, in_valid4, in_ready4, out_valid4, out_ready4;
   logic [31:0] instr_in4, instr_out4;
   logic [63:0] pc_in4, pc_out4;
   logic [2:0]  count4;

   if_id_stage_buf #(.INSTR_W(32), .PC_W(64), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst2), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
      .instruction_in(instr_in2), .pc_in(pc_in2), .out_valid(out_valid2), .out_ready(out_ready2),
      .instruction_out(instr_out2), .pc_out(pc_out2), .count(count2)
   );

   if_id_stage_buf #(.INSTR_W(32), .PC_W(64), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst4), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
      .instruction_in(instr_in4), .pc_in(pc_in4), .out_valid(out_valid4), .out_ready(out_ready4),
      .instruction_out(instr_out4), .pc_out(pc_out4), .count(count4)
   );

   if_id_entry_t q2[$];
   if_id_entry_t q4[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check2(input string tag);
      int sz = q2.size();
      chk({tag, " count2"},     64'(count2),     64'(sz));
      chk({tag, " out_valid2"}, 64'(out_valid2), 64'(sz != 0));
      chk({tag, " in_ready2"},  64'(in_ready2),  64'(sz != 2));
      chk({tag, " instr2"},     64'(instr_out2), 64'((sz != 0) ? q2[0].instr : BUBBLE_INSTR));
      chk({tag, " pc2"},        pc_out2,         (sz != 0) ? q2[0].pc : 64'd0);
   endtask

   task automatic check4(input string tag);
      int sz = q4.size();
      chk({tag, " count4"},     64'(count4),     64'(sz));
      chk({tag, " out_valid4"}, 64'(out_valid4), 64'(sz != 0));
      chk({tag, " in_ready4"},  64'(in_ready4),  64'(sz != 4));
      chk({tag, " instr4"},     64'(instr_out4), 64'((sz != 0) ? q4[0].instr : BUBBLE_INSTR));
      chk({tag, " pc4"},        pc_out4,         (sz != 0) ? q4[0].pc : 64'd0);
   endtask

   // One clock of the DEPTH=2 instance; the reference applies the buffer rules to a queue.
   task automatic step2(input string tag, input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [63:0] pc, input logic ordy, output logic accepted);
      int sz = q2.size();
      flush2 = fl; in_valid2 = iv; instr_in2 = ins; pc_in2 = pc; out_ready2 = ordy;
      @(posedge clk);
      #1;
      accepted = iv && (sz != 2) && !fl;
      if (fl) q2.delete();
      else begin
         if (ordy && sz != 0) void'(q2.pop_front());
         if (iv && sz != 2) q2.push_back('{instr: ins, pc: pc});
      end
      flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
      check2(tag);
   endtask

   task automatic step4(input string tag, input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [63:0] pc, input logic ordy, output logic accepted);
      int sz = q4.size();
      flush4 = fl; in_valid4 = iv; instr_in4 = ins; pc_in4 = pc; out_ready4 = ordy;
      @(posedge clk);
      #1;
      accepted = iv && (sz != 4) && !fl;
      if (fl) q4.delete();
      else begin
         if (ordy && sz != 0) void'(q4.pop_front());
         if (iv && sz != 4) q4.push_back('{instr: ins, pc: pc});
      end
      flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
      check4(tag);
   endtask

   initial begin
      logic         acc;
      logic [31:0]  r_instr;
      if_id_entry_t src[$];
      if_id_entry_t got[$];
      int           n_in;
      int           cyc;
      logic         iv, ordy;

      rst2 = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; instr_in2 = '0; pc_in2 = '0;
      rst4 = 1'b0; flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; instr_in4 = '0; pc_in4 = '0;
      #12;
      check2("reset");
      check4("reset");
      chk("reset instr literal", 64'(instr_out2), 64'h0000_0000_D503_201F);
      rst2 = 1'b1; rst4 = 1'b1;
      @(posedge clk); #1;
      check2("idle");

      // streaming at count=1 with decode always ready
      for (int i = 0; i < 4; i++) begin
         step2("stream", 1'b0, 1'b1, 32'h91000421 + 32'(i), 64'(4 * i), 1'b1, acc);
         chk("stream pc", pc_out2, 64'(4 * i));
         chk("stream instr", 64'(instr_out2), 64'(32'h91000421 + 32'(i)));
      end
      step2("stream drain", 1'b0, 1'b0, '0, '0, 1'b1, acc);

      // stall fill: third push is held by the source until space frees
      step2("fill0", 1'b0, 1'b1, 32'hA0000000, 64'h0, 1'b0, acc);
      step2("fill1", 1'b0, 1'b1, 32'hA0000001, 64'h4, 1'b0, acc);
      step2("fill2", 1'b0, 1'b1, 32'hA0000002, 64'h8, 1'b0, acc);
      chk("fill2 accepted", 64'(acc), 64'd0);
      chk("fill2 head pc", pc_out2, 64'h0);
      step2("rel0", 1'b0, 1'b1, 32'hA0000002, 64'h8, 1'b1, acc);
      chk("rel0 no passthrough", 64'(acc), 64'd0);
      chk("rel0 head pc", pc_out2, 64'h4);
      step2("rel1", 1'b0, 1'b1, 32'hA0000002, 64'h8, 1'b1, acc);
      chk("rel1 accepted", 64'(acc), 64'd1);
      chk("rel1 head pc", pc_out2, 64'h8);
      step2("rel2", 1'b0, 1'b0, '0, '0, 1'b1, acc);

      // flush at count=2 with push/pop requested, then at count=1 where both could fire
      step2("fl fill0", 1'b0, 1'b1, 32'hB0000000, 64'h100, 1'b0, acc);
      step2("fl fill1", 1'b0, 1'b1, 32'hB0000001, 64'h104, 1'b0, acc);
      step2("flush full", 1'b1, 1'b1, 32'hB0000002, 64'h108, 1'b1, acc);
      step2("post flush", 1'b0, 1'b0, '0, '0, 1'b1, acc);
      step2("fl one", 1'b0, 1'b1, 32'hB0000003, 64'h10C, 1'b0, acc);
      step2("flush pushpop", 1'b1, 1'b1, 32'hB0000004, 64'h110, 1'b1, acc);
      step2("post flush2", 1'b0, 1'b0, '0, '0, 1'b0, acc);
      step2("after flush push", 1'b0, 1'b1, 32'hB0000005, 64'h114, 1'b0, acc);
      chk("after flush pc", pc_out2, 64'h114);
      step2("after flush drain", 1'b0, 1'b0, '0, '0, 1'b1, acc);

      // wrap-around on DEPTH=4 with random handshakes
      for (int i = 0; i < 10; i++) begin
         r_instr = $urandom();
         src.push_back('{instr: r_instr, pc: 64'h4000 + 64'(8 * i)});
      end
      n_in = 0;
      cyc  = 0;
      while ((n_in < 10 || q4.size() != 0) && cyc < 300) begin
         iv   = (n_in < 10) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 1) == 1);
         if (out_valid4 && ordy) got.push_back('{instr: instr_out4, pc: pc_out4});
         step4("wrap", 1'b0, iv, (n_in < 10) ? src[n_in].instr : 32'h0,
               (n_in < 10) ? src[n_in].pc : 64'h0, ordy, acc);
         if (acc) n_in++;
         cyc++;
      end
      chk("wrap budget", 64'(cyc < 300), 64'd1);
      chk("wrap got size", 64'(got.size()), 64'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < got.size()) begin
            chk("wrap order instr", 64'(got[i].instr), 64'(src[i].instr));
            chk("wrap order pc", got[i].pc, src[i].pc);
         end
      end

      // asynchronous reset between edges at count=3
      step4("ar0", 1'b0, 1'b1, 32'hC0000000, 64'h200, 1'b0, acc);
      step4("ar1", 1'b0, 1'b1, 32'hC0000001, 64'h204, 1'b0, acc);
      step4("ar2", 1'b0, 1'b1, 32'hC0000002, 64'h208, 1'b0, acc);
      #1;
      rst4 = 1'b0;
      q4.delete();
      #1;
      check4("async reset");
      #1;
      rst4 = 1'b1;
      step4("after reset idle", 1'b0, 1'b0, '0, '0, 1'b1, acc);
      step4("after reset push", 1'b0, 1'b1, 32'hC0000009, 64'h300, 1'b1, acc);
      chk("after reset pc", pc_out4, 64'h300);
      step4("after reset drain", 1'b0, 1'b0, '0, '0, 1'b1, acc);
      step4("after reset empty", 1'b0, 1'b0, '0, '0, 1'b1, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_id_stage_buf.md
# if_id_stage_buf

Parametrised successor to the IF/ID pipeline register: a DEPTH-entry elastic buffer between fetch and decode, with valid/ready handshakes on both sides, flush, and bubble insertion when empty. It replaces the single enable-gated register so fetch can run ahead of a stalled decode by up to DEPTH instructions without dropping or duplicating any. It sits between the PC/instruction-memory stage and the decode/register-read stage.

## Interface
Parameters:
- INSTR_W, 32, instruction width in bits
- PC_W, 64, program-counter width in bits
- DEPTH, 2, number of buffer entries; a power of two, at least 2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge
- rst, input, 1, asynchronous active-low reset
- flush, input, 1, discard all buffered entries (branch taken or exception)
- in_valid, input, 1, fetch presents an instruction
- in_ready, output, 1, buffer can accept; equals (count != DEPTH)
- instruction_in, input, INSTR_W, fetched instruction
- pc_in, input, PC_W, PC of instruction_in
- out_valid, output, 1, head entry is valid for decode
- out_ready, input, 1, decode consumes the head this cycle (deasserted = stall)
- instruction_out, output, INSTR_W, head instruction, or BUBBLE_INSTR when out_valid=0
- pc_out, output, PC_W, head PC, or 0 when out_valid=0
- count, output, CNT_W, current occupancy, 0..DEPTH

## Operation
- Circular buffer with rd_ptr/wr_ptr of width $clog2(DEPTH) that wrap modulo DEPTH, plus the occupancy counter.
- Push when in_valid && in_ready: write to entry[wr_ptr], then wr_ptr++.
- Pop when out_valid && out_ready: rd_ptr++.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0). Head data is entry[rd_ptr], muxed to bubble when empty.
- Full (count == DEPTH): in_ready=0, so no push. A pop in the same cycle does not enable a push (no same-cycle pass-through). in_ready rises the cycle after the pop.
- Empty (count == 0): out_valid=0, outputs show the bubble, and out_ready is ignored.
- flush has priority over everything:
  - Next edge: count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop in that cycle is discarded.
  - Entry storage is not cleared.
- in_valid without in_ready: the input is not captured. Fetch must hold it.

## Timing
- Reset (asynchronous, rst=0): count=0, pointers=0, out_valid=0, in_ready=1, instruction_out=BUBBLE_INSTR, pc_out=0. Reset mid-operation drops all entries immediately, without waiting for an edge.
- Latency: an instruction pushed at edge N appears at the outputs with out_valid=1 after edge N (one cycle), provided it is the head.
- Throughput: with out_ready held at 1, one instruction per cycle is sustained indefinitely at count=1.
- After flush at edge N: out_valid=0 and in_ready=1 from edge N on. The first post-flush push is visible after edge N+1.
- in_ready, out_valid and count are driven from registered state only. No combinational path runs from in_valid/out_ready to in_ready/out_valid.

## Structure
- The shared package `structures` holds:
  - typedef if_id_entry_t, a packed struct {instr, pc}
  - localparam BUBBLE_INSTR = 32'hD503201F (A64 NOP)
- One sub-module, `stage_buf_mem`: a DEPTH x (INSTR_W+PC_W) register array with write enable, write address and asynchronous read address. The top level owns the pointers, counter, flush and bubble mux.

## Test plan
- Reset then idle: rst=0 pulse → count=0, out_valid=0, instruction_out=32'hD503201F, pc_out=0, in_ready=1.
- Streaming: push PC 0x0,0x4,0x8,0xC with instructions 0x91000421.. and out_ready=1 → each appears one cycle later in order, and count stays 1.
- Stall fill: out_ready=0 and push 3 with DEPTH=2 → first two accepted, count=2, in_ready=0, the third is held by the source. Release out_ready → outputs 0x0 then 0x4, then the third is accepted.
- Flush with simultaneous push/pop at count=2 → next cycle count=0, out_valid=0, and neither the pushed nor the popped entry reappears.
- Wrap-around: DEPTH=4, push/pop 10 entries with random out_ready → output order and PCs exactly match input, and count never exceeds 4.
- Asynchronous reset at count=3, asserted between edges → out_valid drops before the next edge and no stale entry is emitted after release.
